// File: rtl/mv_xform_sched_if.sv
// rtl/mv_xform_sched_if.sv - config, vertex, datapath and result ports of the matrix-vector scheduler
interface mv_xform_sched_if #(
    parameter int IDW = 8
);
    logic           cfg_we;
    logic [3:0]     cfg_addr;
    logic [31:0]    cfg_wdata;
    logic           cfg_commit;
    logic           cfg_busy;

    logic           s_valid;
    logic           s_ready;
    logic [IDW-1:0] s_id;
    logic [127:0]   s_vec;

    logic           dp_in_valid;
    logic [IDW-1:0] dp_in_id;
    logic [127:0]   dp_vec;
    logic [511:0]   dp_mat;
    logic           dp_out_valid;
    logic [IDW-1:0] dp_out_id;
    logic [127:0]   dp_out_vec;

    logic           m_valid;
    logic           m_ready;
    logic [IDW-1:0] m_id;
    logic [127:0]   m_vec;

    logic           err_ovf;

    // scheduler side
    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        output cfg_busy,
        input  s_valid, s_id, s_vec,
        output s_ready,
        output dp_in_valid, dp_in_id, dp_vec, dp_mat,
        input  dp_out_valid, dp_out_id, dp_out_vec,
        output m_valid, m_id, m_vec,
        input  m_ready,
        output err_ovf
    );

    // environment side: config host, vertex source, datapath, result sink
    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        input  cfg_busy,
        output s_valid, s_id, s_vec,
        input  s_ready,
        input  dp_in_valid, dp_in_id, dp_vec, dp_mat,
        output dp_out_valid, dp_out_id, dp_out_vec,
        input  m_valid, m_id, m_vec,
        output m_ready,
        input  err_ovf
    );
endinterface

// File: rtl/mv_xform_sched.sv
// rtl/mv_xform_sched.sv - issue/config scheduler for the fixed-latency 4x4 fp32 matrix-vector pipeline
module mv_xform_sched #(
    parameter int IDW        = 8,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mv_xform_sched_if.master bus
);
    // The result FIFO is never built shallower than what one issue per cycle needs.
    localparam int DEPTH = (FIFO_DEPTH < LATENCY + 2) ? LATENCY + 2 : FIFO_DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [31:0]   FP_ONE     = 32'h3F80_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [127:0]   vec;
    } entry_t;

    state_t        state;
    state_t        state_nx;
    logic          busy;

    logic [31:0]   shadow [16];
    logic [31:0]   active [16];

    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   occupancy;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];
    entry_t        head;

    logic          ready;
    logic          issue;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic          err_ovf_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both results still in the pipe and results parked in the FIFO.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign ready     = (state == RUN) && (occupancy < CREDIT_MAX);
    assign issue     = bus.s_valid && ready;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && bus.m_ready;
    assign push      = bus.dp_out_valid && ((fifo_cnt != CNT_FULL) || pop);
    assign head      = mem[rd_ptr];

    assign bus.s_ready     = ready;
    assign bus.dp_in_valid = issue;
    assign bus.dp_in_id    = bus.s_id;
    assign bus.dp_vec      = bus.s_vec;
    assign bus.m_valid     = out_valid;
    assign bus.m_id        = head.id;
    assign bus.m_vec       = head.vec;
    assign bus.cfg_busy    = busy;
    assign bus.err_ovf     = err_ovf_q;

    always_comb begin
        bus.dp_mat = '0;
        for (int k = 0; k < 16; k++) begin
            bus.dp_mat[32*k +: 32] = active[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // A commit arriving while one is already in progress is dropped, not queued.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            RUN: begin
                if (bus.cfg_commit) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (inflight == '0) begin
                    state_nx = SWAP;
                end
            end
            SWAP: begin
                busy     = 1'b1;
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // Copy reads shadow before this cycle's write lands, so a SWAP-cycle write waits for the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                shadow[k] <= (k % 5 == 0) ? FP_ONE : 32'h0;
                active[k] <= (k % 5 == 0) ? FP_ONE : 32'h0;
            end
        end else begin
            if (state == SWAP) begin
                for (int k = 0; k < 16; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (bus.cfg_we) begin
                shadow[bus.cfg_addr] <= bus.cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (issue && !bus.dp_out_valid) begin
            inflight <= inflight + 1'b1;
        end else if (!issue && bus.dp_out_valid && (inflight != '0)) begin
            inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
        end else if (bus.dp_out_valid && (inflight == '0)) begin
            err_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.dp_out_id, bus.dp_out_vec};
        end
    end
endmodule

// File: tb/tb_mv_xform_sched.sv
// tb/tb_mv_xform_sched.sv - directed bench for mv_xform_sched with an fp32 datapath model
module tb_mv_xform_sched;
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;

    typedef struct {
        logic [7:0]   id;
        logic [127:0] vec;
    } exp_t;

    logic clk;
    logic rst;
    logic inject;

    mv_xform_sched_if #(.IDW(8)) bus ();

    mv_xform_sched #(.IDW(8), .LATENCY(4), .FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   out_cnt = 0;
    int   run = 0;
    int   max_run = 0;
    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic        s;
        int          e;
        real         a;
        logic [22:0] f;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        f = 23'($rtoi((a - 1.0) * 8388608.0 + 0.5));
        return {s, 8'(e), f};
    endfunction

    function automatic logic [127:0] mat_mul(input logic [511:0] m, input logic [127:0] v);
        logic [127:0] o;
        real          acc;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 0.0;
            for (int c = 0; c < 4; c++) begin
                acc = acc + f2r(m[32*(4*r+c) +: 32]) * f2r(v[32*c +: 32]);
            end
            o[32*r +: 32] = r2f(acc);
        end
        return o;
    endfunction

    function automatic logic [127:0] mkvec(input int a);
        return {ONE, r2f(real'(a + 3)), r2f(real'(a + 2)), r2f(real'(a + 1))};
    endfunction

    // Four-stage datapath model sharing rst with the scheduler.
    logic         pv   [4];
    logic [7:0]   pid  [4];
    logic [127:0] pvec [4];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
        end else begin
            pv[0]   <= bus.dp_in_valid;
            pid[0]  <= bus.dp_in_id;
            pvec[0] <= mat_mul(bus.dp_mat, bus.dp_vec);
            for (int i = 1; i < 4; i++) begin
                pv[i]   <= pv[i-1];
                pid[i]  <= pid[i-1];
                pvec[i] <= pvec[i-1];
            end
        end
    end

    assign bus.dp_out_valid = pv[3] | inject;
    assign bus.dp_out_id    = pid[3];
    assign bus.dp_out_vec   = pvec[3];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.m_valid) begin
                    run++;
                    if (run > max_run) max_run = run;
                end else begin
                    run = 0;
                end
                if (bus.m_valid && bus.m_ready) begin
                    out_cnt++;
                    if (sb.size() == 0) begin
                        check("spurious_out", 128'(bus.m_valid), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        check("out_id", 128'(bus.m_id), 128'(e.id));
                        check("out_vec", bus.m_vec, e.vec);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] id, input logic [127:0] vec, output logic acc);
        bus.s_valid = 1'b1;
        bus.s_id    = id;
        bus.s_vec   = vec;
        #1;
        acc = bus.s_ready;
    endtask

    task automatic expect_out(input logic [7:0] id, input logic [127:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        sb.push_back(e);
    endtask

    task automatic send_n(input int n, input logic [7:0] id0, input logic [127:0] vec,
                          input logic [127:0] want);
        int   acc;
        logic a;
        acc = 0;
        for (int c = 0; c < 200 && acc < n; c++) begin
            offer(id0 + 8'(acc), vec, a);
            if (a) begin
                expect_out(id0 + 8'(acc), want);
                acc++;
            end
            cyc();
        end
        bus.s_valid = 1'b0;
        check("send_count", 128'(acc), 128'(n));
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 200) begin
            cyc();
            c++;
        end
        check("drain_left", 128'(sb.size()), 128'(0));
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        cyc();
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        logic [511:0] ident;
        logic         a;
        int           acc;
        int           low;
        int           busy_n;
        int           bad;
        int           cnt0;
        logic         committed;
        logic [31:0]  word;

        rst = 1'b1;
        inject = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_wdata = '0;
        bus.cfg_commit = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_id = '0;
        bus.s_vec = '0;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 16; k++) ident[32*k +: 32] = (k % 5 == 0) ? ONE : 32'h0;
        repeat (3) cyc();
        rst = 1'b0;

        check("rst_m_valid", 128'(bus.m_valid), 128'(0));
        check("rst_cfg_busy", 128'(bus.cfg_busy), 128'(0));
        check("rst_err_ovf", 128'(bus.err_ovf), 128'(0));
        check("rst_dp_in_valid", 128'(bus.dp_in_valid), 128'(0));
        check("rst_s_ready", 128'(bus.s_ready), 128'(1));
        check("rst_mat_lo", bus.dp_mat[255:0], ident[255:0]);
        check("rst_mat_hi", bus.dp_mat[511:256], ident[511:256]);

        // 1: single vertex through identity, latency accept+5
        bus.m_ready = 1'b1;
        offer(8'd3, {ONE, THREE, TWO, ONE}, a);
        check("t1_accept", 128'(a), 128'(1));
        check("t1_dp_in_valid", 128'(bus.dp_in_valid), 128'(1));
        check("t1_dp_vec", bus.dp_vec, {ONE, THREE, TWO, ONE});
        expect_out(8'd3, {ONE, THREE, TWO, ONE});
        cyc();
        bus.s_valid = 1'b0;
        repeat (3) cyc();
        check("t1_m_valid_early", 128'(bus.m_valid), 128'(0));
        cyc();
        check("t1_m_valid", 128'(bus.m_valid), 128'(1));
        check("t1_m_id", 128'(bus.m_id), 128'(3));
        check("t1_m_vec", bus.m_vec, {32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000});
        drain();

        // 2: backpressure, credit stops at FIFO depth
        bus.m_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            offer(8'(acc), mkvec(acc), a);
            if (a) begin
                expect_out(8'(acc), mkvec(acc));
                acc++;
            end
            cyc();
        end
        #1;
        check("t2_accepted", 128'(acc), 128'(8));
        check("t2_s_ready", 128'(bus.s_ready), 128'(0));
        bus.m_ready = 1'b1;
        for (int c = 0; c < 200 && acc < 20; c++) begin
            offer(8'(acc), mkvec(acc), a);
            if (a) begin
                expect_out(8'(acc), mkvec(acc));
                acc++;
            end
            cyc();
        end
        bus.s_valid = 1'b0;
        check("t2_total", 128'(acc), 128'(20));
        drain();

        // 3: sustained throughput
        max_run = 0;
        low = 0;
        acc = 0;
        for (int c = 0; c < 100 && acc < 50; c++) begin
            offer(8'(acc), mkvec(acc + 30), a);
            if (a) begin
                expect_out(8'(acc), mkvec(acc + 30));
                acc++;
            end else begin
                low++;
            end
            cyc();
        end
        bus.s_valid = 1'b0;
        check("t3_ready_low_cycles", 128'(low), 128'(0));
        drain();
        check("t3_valid_run", 128'(max_run), 128'(50));

        // 4: commit of 2*I while streaming ones
        for (int k = 0; k < 4; k++) cfg_write(4'(5 * k), TWO);
        word = ONE;
        busy_n = 0;
        bad = 0;
        acc = 0;
        committed = 1'b0;
        for (int c = 0; c < 60 && acc < 16; c++) begin
            bus.cfg_commit = (acc == 6) && !committed;
            offer(8'(acc), {4{ONE}}, a);
            if (bus.cfg_busy) busy_n++;
            if (bus.s_ready == bus.cfg_busy) bad++;
            if (a) begin
                expect_out(8'(acc), {4{word}});
                acc++;
            end
            if (bus.cfg_commit) begin
                committed = 1'b1;
                word = TWO;
            end
            cyc();
        end
        bus.cfg_commit = 1'b0;
        bus.s_valid = 1'b0;
        check("t4_accepted", 128'(acc), 128'(16));
        check("t4_busy_cycles", 128'(busy_n), 128'(6));
        check("t4_ready_vs_busy", 128'(bad), 128'(0));
        drain();

        // 5: write in SWAP cycle reaches active only on the next commit; repeated commits dropped
        bus.cfg_commit = 1'b1;
        cyc();
        check("t5_busy_drain", 128'(bus.cfg_busy), 128'(1));
        cyc();
        check("t5_busy_swap", 128'(bus.cfg_busy), 128'(1));
        check("t5_ready_swap", 128'(bus.s_ready), 128'(0));
        cfg_write(4'd0, THREE);
        bus.cfg_commit = 1'b0;
        check("t5_busy_run", 128'(bus.cfg_busy), 128'(0));
        check("t5_m00_active", 128'(bus.dp_mat[31:0]), 128'(TWO));
        send_n(4, 8'd100, {4{ONE}}, {4{TWO}});
        drain();
        bus.cfg_commit = 1'b1;
        cyc();
        bus.cfg_commit = 1'b0;
        repeat (2) cyc();
        check("t5_busy_after", 128'(bus.cfg_busy), 128'(0));
        send_n(4, 8'd110, {4{ONE}}, {TWO, TWO, TWO, THREE});
        drain();

        // overflow flag on an unsolicited result
        bus.m_ready = 1'b0;
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        check("ovf_set", 128'(bus.err_ovf), 128'(1));
        cyc();
        check("ovf_sticky", 128'(bus.err_ovf), 128'(1));

        // 6: reset with results in flight and parked
        send_n(7, 8'd60, {4{ONE}}, {4{TWO}});
        check("t6_pre_m_valid", 128'(bus.m_valid), 128'(1));
        rst = 1'b1;
        sb.delete();
        cyc();
        rst = 1'b0;
        check("t6_m_valid", 128'(bus.m_valid), 128'(0));
        check("t6_err_ovf", 128'(bus.err_ovf), 128'(0));
        check("t6_mat_lo", bus.dp_mat[255:0], ident[255:0]);
        bus.m_ready = 1'b1;
        cnt0 = out_cnt;
        repeat (10) cyc();
        check("t6_no_outputs", 128'(out_cnt - cnt0), 128'(0));
        send_n(1, 8'd42, {ONE, THREE, TWO, ONE}, {ONE, THREE, TWO, ONE});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
